// File: rtl/prog_freq_divider.sv
// -----------------------------------------------------------------------------
// prog_freq_divider
//
// Runtime-programmable frequency divider. The counter runs 0..N-1, where N is
// the active divisor (div_act). A new divisor is captured into a shadow
// register by a load strobe and is only promoted to div_act at a wrap. This
// keeps every output period whole: a period never gets cut short or stretched
// part-way through.
//
// Output modes (mode is sampled on every enabled edge):
//   mode = 0 : toggle. fout inverts on each wrap, giving a 50% duty output
//              with a period of 2*div_act.
//   mode = 1 : pulse. fout is a one-cycle strobe in the cycle after tc,
//              repeating every div_act cycles.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous reset, active low
//   en       in   count enable; 0 freezes count, fout and div_act
//   mode     in   0 = toggle output, 1 = pulse output
//   load     in   one-cycle strobe; captures div_val (accepted regardless of en)
//   div_val  in   requested divisor; 0 and 1 are clamped to 2
//   count    out  current counter value
//   tc       out  terminal count, combinational: en & (count == div_act-1)
//   fout     out  divided output, registered
//   pend     out  registered; 1 while a loaded divisor waits for a wrap
// -----------------------------------------------------------------------------
module prog_freq_divider #(
    parameter int WIDTH       = 4,
    parameter int DEFAULT_DIV = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] div_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             fout,
    output logic             pend
);

    localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_div_act;
    logic [WIDTH-1:0] r_shadow;
    logic             r_fout;
    logic             r_pend;

    logic [WIDTH-1:0] w_div_clamped;
    logic             w_last;
    logic             w_wrap;

    // Divisors below 2 would make the counter degenerate (no toggle period,
    // or a wrap every cycle with no room for the pulse to fall), so they are
    // raised to 2 on capture.
    assign w_div_clamped = (div_val < MIN_DIV) ? MIN_DIV : div_val;

    // div_act is always >= 2, so div_act-1 never underflows.
    assign w_last = (r_count == (r_div_act - WIDTH'(1)));
    assign w_wrap = en & w_last;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count   <= '0;
            r_div_act <= RST_DIV;
            r_shadow  <= RST_DIV;
            r_fout    <= 1'b0;
            r_pend    <= 1'b0;
        end else begin
            // The shadow follows load whether or not the counter is enabled;
            // the last load before a wrap wins.
            if (load) begin
                r_shadow <= w_div_clamped;
            end

            if (w_wrap) begin
                r_count <= '0;
                // A load landing exactly on the wrap bypasses the shadow so
                // the new divisor applies to the very next period.
                r_div_act <= load ? w_div_clamped : r_shadow;
                r_pend    <= 1'b0;
            end else begin
                if (en) begin
                    r_count <= r_count + WIDTH'(1);
                end
                if (load) begin
                    r_pend <= 1'b1;
                end
            end

            // fout only moves on enabled edges. In toggle mode it flips at a
            // wrap; in pulse mode it mirrors the wrap, which also clears a
            // leftover high level inherited from toggle mode.
            if (en) begin
                if (mode) begin
                    r_fout <= w_wrap;
                end else if (w_wrap) begin
                    r_fout <= ~r_fout;
                end
            end
        end
    end

    assign count = r_count;
    assign tc    = w_wrap;
    assign fout  = r_fout;
    assign pend  = r_pend;

endmodule
